ifu_mem_arb: RTL and testbench

Arbitrates the single instruction-memory port between two line-fill requesters: demand misses from the i_cache and fetches from an instruction prefetcher. It sits between those requesters and i_mem_wrap. It keeps one memory transaction outstanding, gives demand priority with a starvation guard for prefetch, coalesces same-line requests, and routes each fill response back to its owner(s).

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_arb_pick.sv | 58 +++++
 rtl/ifu_mem_arb.sv | 137 +++++++++++++
 tb/tb_ifu_mem_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and widths for the instruction-fetch memory arbiter.
package ifu_pkg;

  localparam int LINE_ADDR_W = 28;
  localparam int LINE_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } t_arb_state;

  typedef struct packed {
    logic                   valid;
    logic [LINE_ADDR_W-1:0] addr;
  } t_arb_req;

  typedef struct packed {
    logic dem;
    logic pf;
  } t_arb_owner;

endpackage

// File: rtl/ifu_arb_pick.sv
// Winner selection between demand and prefetch requesters, including
// same-line coalescing and the demand-streak counter that eventually forces
// a waiting prefetch through.
module ifu_arb_pick
  import ifu_pkg::*;
#(
  parameter int MAX_DEMAND_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arb_en,
  input  t_arb_req   dem_req,
  input  t_arb_req   pf_req,
  output t_arb_owner grant
);

  localparam int STREAK_W = $clog2(MAX_DEMAND_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DEMAND_STREAK);

  logic [STREAK_W-1:0] streak;
  logic                coalesce;
  logic                force_pf;

  // Pick the winner; equal addresses share one transaction, a saturated
  // streak hands the slot to the prefetcher, otherwise demand goes first.
  always_comb begin
    coalesce = dem_req.valid && pf_req.valid && (dem_req.addr == pf_req.addr);
    force_pf = pf_req.valid && (streak == STREAK_MAX);
    grant    = '0;
    if (arb_en) begin
      if (coalesce) begin
        grant.dem = 1'b1;
        grant.pf  = 1'b1;
      end else if (force_pf) begin
        grant.pf = 1'b1;
      end else if (dem_req.valid) begin
        grant.dem = 1'b1;
      end else if (pf_req.valid) begin
        grant.pf = 1'b1;
      end
    end
  end

  // Count demand grants that overtook a waiting prefetch; any prefetch grant
  // or an idle prefetcher restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (arb_en) begin
      if (!pf_req.valid || grant.pf) begin
        streak <= '0;
      end else if (grant.dem && (streak != STREAK_MAX)) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifu_mem_arb.sv
// Single-outstanding arbiter for the instruction-memory port, shared by the
// i_cache demand path and the instruction prefetcher. Fill responses are
// routed back to whichever requesters own the line.
// Optional: define IFU_ARB_PF_MERGE_EN to let a demand for the line a
// prefetch is already fetching join that transaction instead of waiting.
module ifu_mem_arb
  import ifu_pkg::*;
#(
  parameter int MAX_DEMAND_STREAK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dem_req_valid,
  input  logic [LINE_ADDR_W-1:0] dem_req_addr,
  output logic                   dem_req_ready,
  output logic                   dem_rsp_valid,
  input  logic                   pf_req_valid,
  input  logic [LINE_ADDR_W-1:0] pf_req_addr,
  output logic                   pf_req_ready,
  output logic                   pf_rsp_valid,
  output logic [LINE_W-1:0]      rsp_data,
  output logic                   mem_req_valid,
  output logic [LINE_ADDR_W-1:0] mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [LINE_W-1:0]      mem_rsp_data,
  output logic                   busy
);

  t_arb_state             state;
  t_arb_state             state_next;
  t_arb_owner             owner;
  t_arb_owner             grant;
  t_arb_req               dem_req;
  t_arb_req               pf_req;
  logic [LINE_ADDR_W-1:0] lat_addr;
  logic                   arb_en;
  logic                   merge_hit;

  assign dem_req = '{valid: dem_req_valid, addr: dem_req_addr};
  assign pf_req  = '{valid: pf_req_valid,  addr: pf_req_addr};

  // Arbitration only happens in IDLE and never while reset is held, so the
  // readys stay low during reset even if requesters are already valid.
  assign arb_en = rst && (state == IDLE);

  ifu_arb_pick #(
    .MAX_DEMAND_STREAK(MAX_DEMAND_STREAK)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .arb_en  (arb_en),
    .dem_req (dem_req),
    .pf_req  (pf_req),
    .grant   (grant)
  );

`ifdef IFU_ARB_PF_MERGE_EN
  // A demand hitting the line an in-flight prefetch is fetching joins it.
  always_comb begin
    merge_hit = rst && ((state == REQ) || (state == WAIT)) &&
                owner.pf && !owner.dem &&
                dem_req_valid && (dem_req_addr == lat_addr);
  end
`else
  assign merge_hit = 1'b0;
`endif

  assign dem_req_ready = grant.dem | merge_hit;
  assign pf_req_ready  = grant.pf;
  assign mem_req_addr  = lat_addr;
  assign busy          = (state != IDLE);

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state outputs: issue, wait for fill, pulse owners.
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    dem_rsp_valid = 1'b0;
    pf_rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (grant.dem || grant.pf) begin
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_next = RSP;
        end
      end
      RSP: begin
        dem_rsp_valid = owner.dem;
        pf_rsp_valid  = owner.pf;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the granted line and its owners, and capture fill data; fills
  // arriving outside WAIT are stale or spurious and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr <= '0;
      owner    <= '0;
      rsp_data <= '0;
    end else begin
      if (arb_en && (grant.dem || grant.pf)) begin
        lat_addr <= grant.dem ? dem_req_addr : pf_req_addr;
        owner    <= grant;
      end else if (merge_hit) begin
        owner.dem <= 1'b1;
      end
      if ((state == WAIT) && mem_rsp_valid) begin
        rsp_data <= mem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_ifu_mem_arb.sv
// Directed bench for ifu_mem_arb: acts as requesters and as i_mem, with
// expected values written out by hand for each step.
module tb_ifu_mem_arb;

  logic         clk;
  logic         rst;
  logic         dem_req_valid;
  logic [27:0]  dem_req_addr;
  logic         dem_req_ready;
  logic         dem_rsp_valid;
  logic         pf_req_valid;
  logic [27:0]  pf_req_addr;
  logic         pf_req_ready;
  logic         pf_rsp_valid;
  logic [127:0] rsp_data;
  logic         mem_req_valid;
  logic [27:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [27:0] mem_log[$];

  ifu_mem_arb #(
    .MAX_DEMAND_STREAK(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dem_req_valid (dem_req_valid),
    .dem_req_addr  (dem_req_addr),
    .dem_req_ready (dem_req_ready),
    .dem_rsp_valid (dem_rsp_valid),
    .pf_req_valid  (pf_req_valid),
    .pf_req_addr   (pf_req_addr),
    .pf_req_ready  (pf_req_ready),
    .pf_rsp_valid  (pf_rsp_valid),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory request the arbiter hands to i_mem, in order.
  always @(posedge clk) begin
    if (rst && mem_req_valid && mem_req_ready) begin
      mem_log.push_back(mem_req_addr);
    end
  end

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Play i_mem for one transaction already granted: accept the request,
  // return the fill, and check the owner pulses and data.
  task automatic serve_fill(input string tag, input logic [127:0] data,
                            input logic exp_dem, input logic exp_pf);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check_output({tag, "_mem_req_valid"}, mem_req_valid, 1);
    if (!mem_req_valid) return;
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_output({tag, "_dem_rsp"}, dem_rsp_valid, exp_dem);
    check_output({tag, "_pf_rsp"}, pf_rsp_valid, exp_pf);
    check_output({tag, "_rsp_data"}, rsp_data, data);
    tick();
    check_output({tag, "_pulse_end"}, {dem_rsp_valid, pf_rsp_valid}, 0);
    check_output({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int d;
    logic pf_pending;
    logic exp_pf;
    logic [27:0] exp_order[7];

    rst           = 1'b0;
    dem_req_valid = 1'b0;
    dem_req_addr  = '0;
    pf_req_valid  = 1'b0;
    pf_req_addr   = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // Reset state
    tick();
    tick();
    check_output("rst_readys", {dem_req_ready, pf_req_ready}, 0);
    check_output("rst_rsp", {dem_rsp_valid, pf_rsp_valid}, 0);
    check_output("rst_mem_req", mem_req_valid, 0);
    check_output("rst_mem_addr", mem_req_addr, 0);
    check_output("rst_rsp_data", rsp_data, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // Demand only, explicit latency
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h0000010;
    #1;
    check_output("t1_dem_ready", dem_req_ready, 1);
    check_output("t1_pf_ready", pf_req_ready, 0);
    tick();
    dem_req_valid = 1'b0;
    check_output("t1_mem_req_valid", mem_req_valid, 1);
    check_output("t1_mem_req_addr", mem_req_addr, 28'h0000010);
    check_output("t1_busy", busy, 1);
    tick();
    check_output("t1_req_dropped", mem_req_valid, 0);
    tick();
    check_output("t1_no_early_rsp", {dem_rsp_valid, pf_rsp_valid}, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {16{8'hA5}};
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_output("t1_dem_rsp", dem_rsp_valid, 1);
    check_output("t1_pf_rsp", pf_rsp_valid, 0);
    check_output("t1_rsp_data", rsp_data, {16{8'hA5}});
    tick();
    check_output("t1_dem_rsp_one_cycle", dem_rsp_valid, 0);
    check_output("t1_idle", busy, 0);

    // Both valid, different lines: demand first, then prefetch
    mem_log.delete();
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h20;
    pf_req_valid  = 1'b1;
    pf_req_addr   = 28'h30;
    #1;
    check_output("t2_dem_ready", dem_req_ready, 1);
    check_output("t2_pf_wait", pf_req_ready, 0);
    tick();
    dem_req_valid = 1'b0;
    serve_fill("t2_a", {4{32'h1111_2222}}, 1'b1, 1'b0);
    check_output("t2_pf_ready", pf_req_ready, 1);
    tick();
    pf_req_valid = 1'b0;
    serve_fill("t2_b", {4{32'h3333_4444}}, 1'b0, 1'b1);
    check_output("t2_count", mem_log.size(), 2);
    if (mem_log.size() == 2) begin
      check_output("t2_order0", mem_log[0], 28'h20);
      check_output("t2_order1", mem_log[1], 28'h30);
    end

    // Starvation guard: prefetch forced after four demand grants
    mem_log.delete();
    exp_order = '{28'h50, 28'h51, 28'h52, 28'h53, 28'h40, 28'h54, 28'h55};
    d = 0;
    pf_pending = 1'b1;
    for (int k = 0; k < 7; k++) begin
      dem_req_valid = (d < 6);
      dem_req_addr  = 28'h50 + 28'(d);
      pf_req_valid  = pf_pending;
      pf_req_addr   = 28'h40;
      exp_pf        = (k == 4);
      #1;
      check_output($sformatf("t3_dem_ready_%0d", k), dem_req_ready, !exp_pf);
      check_output($sformatf("t3_pf_ready_%0d", k), pf_req_ready, exp_pf);
      if (exp_pf) pf_pending = 1'b0;
      else d++;
      tick();
      dem_req_valid = 1'b0;
      pf_req_valid  = pf_pending;
      serve_fill($sformatf("t3_fill_%0d", k), {4{32'h5000_0000 + 32'(k)}},
                 !exp_pf, exp_pf);
    end
    check_output("t3_count", mem_log.size(), 7);
    if (mem_log.size() == 7) begin
      for (int k = 0; k < 7; k++) begin
        check_output($sformatf("t3_order%0d", k), mem_log[k], exp_order[k]);
      end
    end

    // Coalesce: same line from both requesters
    mem_log.delete();
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h60;
    pf_req_valid  = 1'b1;
    pf_req_addr   = 28'h60;
    #1;
    check_output("t4_both_ready", {dem_req_ready, pf_req_ready}, 2'b11);
    tick();
    dem_req_valid = 1'b0;
    pf_req_valid  = 1'b0;
    serve_fill("t4", {2{64'hDEAD_BEEF_0600_0060}}, 1'b1, 1'b1);
    check_output("t4_one_req", mem_log.size(), 1);

    // Reset during WAIT, late response ignored, then normal operation
    mem_log.delete();
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h80;
    tick();
    dem_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_output("t5_rst_busy", busy, 0);
    check_output("t5_rst_mem_req", mem_req_valid, 0);
    check_output("t5_rst_mem_addr", mem_req_addr, 0);
    check_output("t5_rst_rsp_data", rsp_data, 0);
    tick();
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'hBAD0_BAD0}};
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_output("t5_stale_dem_rsp", dem_rsp_valid, 0);
    check_output("t5_stale_data", rsp_data, 0);
    check_output("t5_stale_busy", busy, 0);
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h90;
    #1;
    check_output("t5_next_ready", dem_req_ready, 1);
    tick();
    dem_req_valid = 1'b0;
    check_output("t5_next_addr", mem_req_addr, 28'h90);
    serve_fill("t5", {4{32'h9090_9090}}, 1'b1, 1'b0);

    // Demand for the line an in-flight prefetch is already fetching
    mem_log.delete();
    pf_req_valid = 1'b1;
    pf_req_addr  = 28'h70;
    #1;
    check_output("t6_pf_ready", pf_req_ready, 1);
    tick();
    pf_req_valid = 1'b0;
    tick();
    dem_req_valid = 1'b1;
    dem_req_addr  = 28'h70;
    #1;
`ifdef IFU_ARB_PF_MERGE_EN
    check_output("t6_merge_ready", dem_req_ready, 1);
    tick();
    dem_req_valid = 1'b0;
    check_output("t6_merge_ready_once", dem_req_ready, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'h7070_7070}};
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_output("t6_both_rsp", {dem_rsp_valid, pf_rsp_valid}, 2'b11);
    check_output("t6_rsp_data", rsp_data, {4{32'h7070_7070}});
    tick();
    check_output("t6_idle", busy, 0);
    check_output("t6_one_req", mem_log.size(), 1);
`else
    check_output("t6_dem_waits", dem_req_ready, 0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {4{32'h7070_7070}};
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    check_output("t6_pf_rsp", {dem_rsp_valid, pf_rsp_valid}, 2'b01);
    check_output("t6_rsp_ready_low", dem_req_ready, 0);
    tick();
    check_output("t6_dem_ready", dem_req_ready, 1);
    tick();
    dem_req_valid = 1'b0;
    serve_fill("t6_dem", {4{32'h7171_7171}}, 1'b1, 1'b0);
    check_output("t6_two_req", mem_log.size(), 2);
    if (mem_log.size() == 2) begin
      check_output("t6_order0", mem_log[0], 28'h70);
      check_output("t6_order1", mem_log[1], 28'h70);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
